// File: rtl/systolic_pkg.sv
// Shared types for the systolic-array output path.
//   collect_state_e : collector FSM states
//   layout_e        : output layout mode (weight- vs output-stationary)
//   idx_width       : bits needed to index n items (never less than 1)
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } collect_state_e;

  typedef enum logic {
    LayoutWs = 1'b0,
    LayoutOs = 1'b1
  } layout_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_col_tracker.sv
// Per-column capture tracker: hold-phase counter, captured-row count,
// capture strobe and sticky overflow for one systolic-array channel.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : start pulse; zeroes phase, count and overflow, blocks capture
//   enable    : collector is in COLLECT
//   valid     : column output-valid from the array
//   capture   : write this column's data this cycle (count is the row index)
//   count     : rows captured so far (0..ROWS)
//   full      : count == ROWS
//   overflow  : a capture was attempted while full
module output_col_tracker
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  localparam int unsigned CntW       = $clog2(ROWS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic            valid,
  output logic            capture,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            overflow
);

  localparam int unsigned PhaseW = idx_width(HOLD_CYCLES);

  logic [PhaseW-1:0] phase_q, phase_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              hit;

  always_comb begin
    full    = (count_q == CntW'(ROWS));
    // Each held output is sampled once, on the first cycle of its hold window.
    hit     = enable && valid && (phase_q == '0) && !clear;
    capture = hit && !full;
    phase_d = phase_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      phase_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (!valid || (phase_q == PhaseW'(HOLD_CYCLES - 1))) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
      if (capture) begin
        count_d = count_q + 1'b1;
      end
      if (hit && full) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/matmul_output_collector.sv
// Collects held per-column outputs of a systolic array into a ROWS x COLS matrix.
// Weight-stationary layout writes [k][c]; output-stationary writes [c][COLS-1-k]
// (only when ROWS == COLS, otherwise forced to weight-stationary).
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   start         : one-cycle pulse; clears counters and begins a new matrix
//   os_mode       : layout select, sampled on start
//   col_valid     : per-column valid
//   col_data      : packed column data, column c at [c*WORD_SIZE +: WORD_SIZE]
//   output_matrix : collected matrix, element [r][c]
//   busy          : in COLLECT
//   done          : one-cycle pulse when every column holds ROWS entries
//   overflow      : sticky; capture attempted on a completed column
// Build option: define OUTPUT_CLEAR_ON_START_EN to also zero output_matrix on start.
module matmul_output_collector
  import systolic_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLS        = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      os_mode,
  input  logic [COLS-1:0]                           col_valid,
  input  logic [COLS*WORD_SIZE-1:0]                 col_data,
  output logic [ROWS-1:0][COLS-1:0][WORD_SIZE-1:0] output_matrix,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      overflow
);

  localparam int unsigned CntW    = $clog2(ROWS + 1);
  localparam int unsigned RowW    = idx_width(ROWS);
  localparam int unsigned ColW    = idx_width(COLS);
  localparam bit          OsLegal = (ROWS == COLS);

  collect_state_e state_q, state_d;
  layout_e        mode_q, mode_d;

  logic [ROWS-1:0][COLS-1:0][WORD_SIZE-1:0] matrix_q, matrix_d;

  logic [COLS-1:0] col_capture;
  logic [COLS-1:0] col_full;
  logic [COLS-1:0] col_ovf;
  logic [CntW-1:0] col_count [COLS];
  logic            collecting;
  logic [RowW-1:0] row_idx;
  logic [ColW-1:0] col_idx;

  assign collecting = (state_q == StCollect);

  for (genvar g = 0; g < COLS; g++) begin : g_col
    output_col_tracker #(
      .ROWS        (ROWS),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_tracker (
      .clk      (clk),
      .rst      (rst),
      .clear    (start),
      .enable   (collecting),
      .valid    (col_valid[g]),
      .capture  (col_capture[g]),
      .count    (col_count[g]),
      .full     (col_full[g]),
      .overflow (col_ovf[g])
    );
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q == StCollect);
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StCollect;
      end
      StCollect: begin
        // A restart wins over completion so no done pulse escapes a restart.
        if (start) begin
          state_d = StCollect;
        end else if (&col_full) begin
          state_d = StDone;
          done    = 1'b1;
        end
      end
      StDone: begin
        if (start) state_d = StCollect;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    if (start) begin
      mode_d = (OsLegal && os_mode) ? LayoutOs : LayoutWs;
    end
  end

  always_comb begin
    matrix_d = matrix_q;
`ifdef OUTPUT_CLEAR_ON_START_EN
    if (start) matrix_d = '0;
`endif
    row_idx = '0;
    col_idx = '0;
    // Trackers suppress capture on start, so no write collides with a clear.
    for (int c = 0; c < COLS; c++) begin
      if (col_capture[c]) begin
        if (mode_q == LayoutOs) begin
          row_idx = RowW'(c);
          col_idx = ColW'(COLS - 1) - ColW'(col_count[c]);
        end else begin
          row_idx = RowW'(col_count[c]);
          col_idx = ColW'(c);
        end
        matrix_d[row_idx][col_idx] = col_data[c*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      mode_q   <= LayoutWs;
      matrix_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      matrix_q <= matrix_d;
    end
  end

  assign output_matrix = matrix_q;
  assign overflow      = |col_ovf;

endmodule

// File: tb/tb_matmul_output_collector.sv
module tb_matmul_output_collector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance with HOLD_CYCLES = 2
  logic                     start2 = 1'b0, os2 = 1'b0;
  logic [3:0]               valid2 = '0;
  logic [63:0]              data2  = '0;
  logic [3:0][3:0][15:0]    mat2;
  logic                     busy2, done2, ovf2;

  // Instance with HOLD_CYCLES = 1
  logic                     start1 = 1'b0, os1 = 1'b0;
  logic [3:0]               valid1 = '0;
  logic [63:0]              data1  = '0;
  logic [3:0][3:0][15:0]    mat1;
  logic                     busy1, done1, ovf1;

  matmul_output_collector #(
    .WORD_SIZE (16), .ROWS (4), .COLS (4), .HOLD_CYCLES (2)
  ) u_dut2 (
    .clk           (clk),
    .rst           (rst),
    .start         (start2),
    .os_mode       (os2),
    .col_valid     (valid2),
    .col_data      (data2),
    .output_matrix (mat2),
    .busy          (busy2),
    .done          (done2),
    .overflow      (ovf2)
  );

  matmul_output_collector #(
    .WORD_SIZE (16), .ROWS (4), .COLS (4), .HOLD_CYCLES (1)
  ) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .start         (start1),
    .os_mode       (os1),
    .col_valid     (valid1),
    .col_data      (data1),
    .output_matrix (mat1),
    .busy          (busy1),
    .done          (done1),
    .overflow      (ovf1)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_cnt;
    int done_at;

    // Reset state
    step();
    step();
    check_val("rst_busy", busy2, 1'b0);
    check_val("rst_done", done2, 1'b0);
    check_val("rst_ovf", ovf2, 1'b0);
    check_val("rst_mat_zero", (mat2 == '0), 1'b1);
    rst = 1'b1;

    // col_valid ignored in IDLE
    valid2 = 4'hf;
    data2  = {4{16'h00aa}};
    step();
    step();
    valid2 = '0;
    check_val("idle_ignore", (mat2 == '0), 1'b1);
    check_val("idle_busy", busy2, 1'b0);

    // WS, HOLD=2, column c valid cycles 1+c..8+c, data 10*k+c
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check_val("ws_busy", busy2, 1'b1);
    done_cnt = 0;
    done_at  = -1;
    for (int j = 1; j <= 12; j++) begin
      for (int c = 0; c < 4; c++) begin
        if (j >= 1 + c && j <= 8 + c) begin
          valid2[c]          = 1'b1;
          data2[c*16 +: 16]  = 16'(10 * ((j - 1 - c) / 2) + c);
        end else begin
          valid2[c]          = 1'b0;
          data2[c*16 +: 16]  = '0;
        end
      end
      step();
      if (done2) begin
        done_cnt++;
        done_at = j;
      end
    end
    valid2 = '0;
    check_val("ws_done_cnt", done_cnt, 1);
    check_val("ws_done_at", done_at, 10);
    check_val("ws_ovf", ovf2, 1'b0);
    check_val("ws_busy_end", busy2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        check_val($sformatf("ws_m%0d%0d", k, c), mat2[k][c], 10 * k + c);
      end
    end

    // Start after a full matrix; then overflow on column 0
    start2 = 1'b1;
    step();
    start2 = 1'b0;
`ifdef OUTPUT_CLEAR_ON_START_EN
    check_val("clr_on_start", mat2[1][2], 0);
`else
    check_val("keep_on_start", mat2[1][2], 12);
`endif
    check_val("of_busy", busy2, 1'b1);
    for (int j = 1; j <= 10; j++) begin
      valid2      = 4'b0001;
      data2[15:0] = 16'h0500 + 16'(j);
      step();
    end
    valid2 = '0;
    check_val("of_flag", ovf2, 1'b1);
    check_val("of_m00", mat2[0][0], 16'h0501);
    check_val("of_m30_kept", mat2[3][0], 16'h0507);
    check_val("of_busy_still", busy2, 1'b1);

    // Restart after two rows
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check_val("rs_ovf_clr", ovf2, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      valid2 = 4'hf;
      data2  = {4{16'h0600 + 16'((j - 1) / 2)}};
      step();
    end
    check_val("rs_row1", mat2[1][3], 16'h0601);
    valid2 = '0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check_val("rs_busy", busy2, 1'b1);
    done_cnt = 0;
    done_at  = -1;
    for (int j = 1; j <= 10; j++) begin
      valid2 = (j <= 8) ? 4'hf : 4'h0;
      data2  = {4{16'h0700 + 16'((j - 1) / 2)}};
      step();
      if (done2) begin
        done_cnt++;
        done_at = j;
      end
    end
    valid2 = '0;
    check_val("rs_done_cnt", done_cnt, 1);
    check_val("rs_done_at", done_at, 7);
    check_val("rs_m00", mat2[0][0], 16'h0700);
    check_val("rs_m12", mat2[1][2], 16'h0701);
    check_val("rs_m31", mat2[3][1], 16'h0703);

    // OS, HOLD=1, all columns valid 4 cycles, data 0x100+k
    start1 = 1'b1;
    os1    = 1'b1;
    step();
    start1 = 1'b0;
    os1    = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      valid1 = 4'hf;
      data1  = {4{16'h0100 + 16'(j - 1)}};
      step();
      if (j == 3) check_val("os_done_early", done1, 1'b0);
      if (j == 4) check_val("os_done", done1, 1'b1);
    end
    valid1 = '0;
    step();
    check_val("os_done_pulse", done1, 1'b0);
    check_val("os_busy_end", busy1, 1'b0);
    check_val("os_ovf", ovf1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        check_val($sformatf("os_m%0d%0d", c, 3 - k), mat1[c][3-k], 16'h0100 + k);
      end
    end

    // Async reset mid-COLLECT
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    valid2 = 4'hf;
    data2  = {4{16'h0bad}};
    step();
    check_val("ar_pre", mat2[0][0], 16'h0bad);
    #3;
    rst = 1'b0;
    #1;
    check_val("ar_mat_zero", (mat2 == '0), 1'b1);
    check_val("ar_mat1_zero", (mat1 == '0), 1'b1);
    check_val("ar_busy", busy2, 1'b0);
    check_val("ar_ovf", ovf2, 1'b0);
    #1;
    rst = 1'b1;
    step();
    step();
    check_val("ar_idle_ignore", mat2[0][0], 16'h0000);
    check_val("ar_idle_busy", busy2, 1'b0);
    data2  = {4{16'h00c0}};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check_val("ar_start_busy", busy2, 1'b1);
    step();
    check_val("ar_capture", mat2[0][1], 16'h00c0);
    valid2 = '0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
